// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command path: opcodes, sequencer states and
// the buffered command format.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  localparam logic [2:0] OP_NOT = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_DEC = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_INC = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] a;
    logic [ALU_WIDTH-1:0] b;
    logic [2:0]           f;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU sequencer. Callers never push when full or pop
// when empty; count tells full from empty since the pointers wrap.
module alu_cmd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [2*WIDTH+2:0]           push_cmd,
  input  logic                         pop,
  output logic [2*WIDTH+2:0]           head,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CMD_W = 2 * WIDTH + 3;

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; count gates every read, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_cmd;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands and issues them one at a time to a combinational ALU,
// returning results in order. Define ALU_SEQ_FLAGS_EN to add res_zero/res_neg.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  input  logic [2:0]             in_f,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [2:0]             alu_f,
  input  logic [WIDTH-1:0]       alu_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_data,
  output logic [2:0]             res_f,
`ifdef ALU_SEQ_FLAGS_EN
  output logic                   res_zero,
  output logic                   res_neg,
`endif
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  seq_state_e       state_q, state_d;
  alu_cmd_t         push_cmd, head_cmd;
  logic             push, pop;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;

  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]       alu_f_q, alu_f_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [2:0]       res_f_q, res_f_d;

  // Full refuses input even if a pop happens this cycle, keeping in_ready off the FSM path.
  assign in_ready   = (fifo_count != CNT_W'(DEPTH));
  assign push       = in_valid && in_ready;
  assign push_cmd   = '{a: in_a, b: in_b, f: in_f};
  assign fifo_empty = (fifo_count == '0);

  alu_cmd_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_cmd (push_cmd),
    .pop      (pop),
    .head     (head_cmd),
    .count    (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_f_d     = res_f_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        res_valid_d = 1'b1;
        res_data_d  = alu_out;
        res_f_d     = alu_f_q;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          pop         = !fifo_empty;
          state_d     = fifo_empty ? ST_IDLE : ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Operand registers only move on a pop and otherwise keep the last command.
    alu_a_d = pop ? head_cmd.a : alu_a_q;
    alu_b_d = pop ? head_cmd.b : alu_b_q;
    alu_f_d = pop ? head_cmd.f : alu_f_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_f_q     <= OP_NOT;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_f_q     <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_f_q     <= alu_f_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_f_q     <= res_f_d;
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic res_zero_q, res_zero_d, res_neg_q, res_neg_d;

  always_comb begin
    res_zero_d = res_zero_q;
    res_neg_d  = res_neg_q;
    if (state_q == ST_ISSUE) begin
      res_zero_d = (alu_out == '0);
      res_neg_d  = alu_out[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_zero_q <= 1'b0;
      res_neg_q  <= 1'b0;
    end else begin
      res_zero_q <= res_zero_d;
      res_neg_q  <= res_neg_d;
    end
  end

  assign res_zero = res_zero_q;
  assign res_neg  = res_neg_q;
`endif

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_f     = alu_f_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_f     = res_f_q;
  assign count     = fifo_count;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural 32-bit ALU attached.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [2:0]  in_f;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_f;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [2:0]  res_f;
  logic [2:0]  count;
  logic        busy;
`ifdef ALU_SEQ_FLAGS_EN
  logic        res_zero, res_neg;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_interval = 1'b0;
  logic [31:0] exp_data_q[$];
  logic [2:0]  exp_f_q[$];

  alu_cmd_sequencer #(.WIDTH(32), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_f      (in_f),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_f     (alu_f),
    .alu_out   (alu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_f     (res_f),
`ifdef ALU_SEQ_FLAGS_EN
    .res_zero  (res_zero),
    .res_neg   (res_neg),
`endif
    .count     (count),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    case (alu_f)
      OP_NOT:  alu_out = ~alu_a;
      OP_AND:  alu_out = alu_a & alu_b;
      OP_XOR:  alu_out = alu_a ^ alu_b;
      OP_OR:   alu_out = alu_a | alu_b;
      OP_DEC:  alu_out = alu_a - 32'd1;
      OP_ADD:  alu_out = alu_a + alu_b;
      OP_SUB:  alu_out = alu_a - alu_b;
      default: alu_out = alu_a + 32'd1;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_f     = f;
  endtask

  // Collect results while res_ready is high; each valid lasts one sample.
  task automatic drain(input string tag, input int budget);
    logic [31:0] ed;
    logic [2:0]  ef;
    int last = -1;
    for (int c = 0; c < budget && exp_data_q.size() != 0; c++) begin
      if (res_valid) begin
        ed = exp_data_q.pop_front();
        ef = exp_f_q.pop_front();
        check({tag, "_data"}, res_data, ed);
        check({tag, "_f"}, res_f, ef);
`ifdef ALU_SEQ_FLAGS_EN
        check({tag, "_zero"}, res_zero, (ed == 32'd0));
        check({tag, "_neg"}, res_neg, ed[31]);
`endif
        if (chk_interval && last >= 0) check({tag, "_interval"}, cyc - last, 2);
        last = cyc;
      end
      tick();
    end
    check({tag, "_all_drained"}, exp_data_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_f = '0; res_ready = 1'b0;
    repeat (2) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_f", res_f, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_f", alu_f, 0);
    rst_n = 1'b1;
    tick();

    // Single add: accept at N, issue at N+1, result after N+2.
    res_ready = 1'b1;
    drive(32'd5, 32'd3, OP_ADD);
    tick();
    in_valid = 1'b0;
    check("add_count_n", count, 1);
    check("add_busy_n", busy, 1);
    tick();
    check("add_alu_a", alu_a, 5);
    check("add_alu_b", alu_b, 3);
    check("add_alu_f", alu_f, OP_ADD);
    check("add_valid_n1", res_valid, 0);
    tick();
    check("add_valid_n2", res_valid, 1);
    check("add_data", res_data, 8);
    check("add_res_f", res_f, OP_ADD);
`ifdef ALU_SEQ_FLAGS_EN
    check("add_zero", res_zero, 0);
    check("add_neg", res_neg, 0);
`endif
    tick();
    check("add_valid_done", res_valid, 0);
    check("add_busy_done", busy, 0);
    check("add_alu_a_kept", alu_a, 5);

    // Decrement of zero wraps to all ones.
    drive(32'd0, 32'd0, OP_DEC);
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    check("dec_valid", res_valid, 1);
    check("dec_data", res_data, 32'hFFFF_FFFF);
    check("dec_res_f", res_f, OP_DEC);
`ifdef ALU_SEQ_FLAGS_EN
    check("dec_zero", res_zero, 0);
    check("dec_neg", res_neg, 1);
`endif
    tick();
    check("dec_busy_done", busy, 0);

    // Fill and stall: first command holds, four more fill the FIFO.
    res_ready = 1'b0;
    drive(32'd10, 32'd3, OP_SUB);       tick();
    drive(32'hF0, 32'h3C, OP_AND);      tick();
    drive(32'hF0, 32'h3C, OP_XOR);      tick();
    drive(32'hF0, 32'h0F, OP_OR);       tick();
    drive(32'h0, 32'h0, OP_NOT);        tick();
    check("fill_count", count, 4);
    check("fill_in_ready", in_ready, 0);
    check("fill_valid", res_valid, 1);
    check("fill_data", res_data, 7);
    check("fill_res_f", res_f, OP_SUB);
    drive(32'd41, 32'd0, OP_INC);
    repeat (2) tick();
    check("stall_count", count, 4);
    check("stall_in_ready", in_ready, 0);
    check("stall_valid", res_valid, 1);
    check("stall_data", res_data, 7);
    res_ready = 1'b1;
    tick();
    check("release_count", count, 3);
    check("release_in_ready", in_ready, 1);
    check("release_valid", res_valid, 0);
    check("release_alu_a", alu_a, 32'hF0);
    tick();
    in_valid = 1'b0;
    check("sixth_count", count, 4);
    exp_data_q = '{32'h30, 32'hCC, 32'hFF, 32'hFFFF_FFFF, 32'd42};
    exp_f_q    = '{OP_AND, OP_XOR, OP_OR, OP_NOT, OP_INC};
    drain("fill", 40);
    check("fill_busy_done", busy, 0);

    // Streaming: a=i, b=1 add; results 1..8 every other cycle.
    for (int i = 0; i < 8; i++) begin
      exp_data_q.push_back(32'(i + 1));
      exp_f_q.push_back(OP_ADD);
    end
    chk_interval = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          int w;
          drive(32'(i), 32'd1, OP_ADD);
          w = 0;
          while (!in_ready && w < 50) begin
            tick();
            w++;
          end
          check("stream_push_bound", (w < 50), 1);
          tick();
        end
        in_valid = 1'b0;
      end
      drain("stream", 60);
    join
    chk_interval = 1'b0;
    repeat (2) tick();
    check("stream_busy_done", busy, 0);

    // Push on the HOLD->ISSUE edge with two queued.
    res_ready = 1'b0;
    drive(32'd100, 32'd1, OP_SUB);      tick();
    drive(32'd7, 32'd0, OP_INC);        tick();
    drive(32'd2, 32'd3, OP_ADD);        tick();
    check("pp_count_before", count, 2);
    check("pp_valid", res_valid, 1);
    check("pp_data_a", res_data, 99);
    drive(32'h8000_0000, 32'd0, OP_DEC);
    res_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("pp_count_after", count, 2);
    check("pp_alu_a", alu_a, 7);
    check("pp_alu_f", alu_f, OP_INC);
    exp_data_q = '{32'd8, 32'd5, 32'h7FFF_FFFF};
    exp_f_q    = '{OP_INC, OP_ADD, OP_DEC};
    drain("pp", 30);

    // Reset while holding a result with three queued.
    res_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(32'(i), 32'd1, OP_ADD);
      tick();
    end
    in_valid = 1'b0;
    check("rh_count_before", count, 3);
    check("rh_valid_before", res_valid, 1);
    check("rh_data_before", res_data, 2);
    rst_n = 1'b0;
    #1;
    check("rh_count_async", count, 0);
    check("rh_valid_async", res_valid, 0);
    check("rh_data_async", res_data, 0);
    check("rh_in_ready_async", in_ready, 1);
    check("rh_busy_async", busy, 0);
    check("rh_alu_a_async", alu_a, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    res_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("rh_no_stale_valid", res_valid, 0);
    end
    check("rh_count_after", count, 0);
    check("rh_data_after", res_data, 0);
    check("rh_busy_after", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
